// File: rtl/iob_native_split.sv
// ---------------------------------------------------------------------------
// iob_native_split
//
// Bridges one native valid/ready CPU memory port (PicoRV32 style) onto N_CH
// IOb channels. The upper SEL_W address bits select the channel. While
// boot_i is high, instruction fetches can be redirected to BOOT_CH. Only one
// transaction is in flight at a time. A watchdog and out-of-range decoding
// both complete the native request with nat_err_o set.
//
// Ports
//   clk_i, arst_i, cke_i   clock, async active-high reset, clock enable
//   boot_i                 boot mode (remaps fetches when USE_BOOT)
//   nat_valid_i            native request, held until nat_ready_o
//   nat_instr_i            request is an instruction fetch
//   nat_addr_i             byte address
//   nat_wdata_i            write data
//   nat_wstrb_i            byte strobes (all zero = read)
//   nat_rdata_o            read data, valid with nat_ready_o
//   nat_ready_o            one-cycle completion pulse
//   nat_err_o              error flag, valid with nat_ready_o
//   iob_avalid_o[N_CH]     per-channel address valid (one-hot or zero)
//   iob_addr_o             latched address, selector = effective channel
//   iob_wdata_o            latched write data
//   iob_wstrb_o            latched byte strobes
//   iob_ready_i[N_CH]      per-channel request accept
//   iob_rvalid_i[N_CH]     per-channel read data valid
//   iob_rdata_i            per-channel read data, channel k at [k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module iob_native_split #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int N_CH      = 2,
   parameter int SEL_W     = 1,
   parameter bit USE_BOOT  = 1'b1,
   parameter int BOOT_CH   = 0,
   parameter int TIMEOUT_W = 8,
   localparam int WSTRB_W  = DATA_W / 8
) (
   input  logic                   clk_i,
   input  logic                   arst_i,
   input  logic                   cke_i,
   input  logic                   boot_i,
   input  logic                   nat_valid_i,
   input  logic                   nat_instr_i,
   input  logic [ADDR_W-1:0]      nat_addr_i,
   input  logic [DATA_W-1:0]      nat_wdata_i,
   input  logic [WSTRB_W-1:0]     nat_wstrb_i,
   output logic [DATA_W-1:0]      nat_rdata_o,
   output logic                   nat_ready_o,
   output logic                   nat_err_o,
   output logic [N_CH-1:0]        iob_avalid_o,
   output logic [ADDR_W-1:0]      iob_addr_o,
   output logic [DATA_W-1:0]      iob_wdata_o,
   output logic [WSTRB_W-1:0]     iob_wstrb_o,
   input  logic [N_CH-1:0]        iob_ready_i,
   input  logic [N_CH-1:0]        iob_rvalid_i,
   input  logic [N_CH*DATA_W-1:0] iob_rdata_i
);

   // Every selector code gets a slot so a SEL_W-bit index never runs past
   // the end; slots at or above N_CH read as idle.
   localparam int N_SEL = 2 ** SEL_W;
   localparam int CNT_W = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      ACK  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [WSTRB_W-1:0]  wstrb_q, wstrb_d;
   logic                we_q, we_d;
   logic [SEL_W-1:0]    ch_q, ch_d;
   logic [N_CH-1:0]     avalid_q, avalid_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [CNT_W-1:0]    wdog_q, wdog_d;

   logic [SEL_W-1:0]    ch_req;
   logic                ch_req_ok;
   logic                wdog_hit;
   logic [N_SEL-1:0]    ready_sel;
   logic [N_SEL-1:0]    rvalid_sel;
   logic [DATA_W-1:0]   rdata_sel [N_SEL];

   // Effective channel of the incoming request: boot remap of fetches wins
   // over the address selector field.
   always_comb begin
      ch_req = nat_addr_i[ADDR_W-1 -: SEL_W];
      if (USE_BOOT && boot_i && nat_instr_i) begin
         ch_req = SEL_W'(BOOT_CH);
      end
   end

   assign ch_req_ok = (32'(ch_req) < 32'(N_CH));

   // Watchdog expires on the cycle its counter sits at the all-ones value.
   assign wdog_hit = (TIMEOUT_W > 0) && (wdog_q == '1);

   // Widen the per-channel inputs to one slot per selector code.
   always_comb begin
      ready_sel  = '0;
      rvalid_sel = '0;
      for (int k = 0; k < N_SEL; k++) begin
         rdata_sel[k] = '0;
      end
      for (int k = 0; k < N_CH; k++) begin
         ready_sel[k]  = iob_ready_i[k];
         rvalid_sel[k] = iob_rvalid_i[k];
         rdata_sel[k]  = iob_rdata_i[k*DATA_W +: DATA_W];
      end
   end

   // Next-state and next-output logic.
   // NOTE: every signal assigned here first gets a hold/default value, so no
   // path through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      we_d    = we_q;
      ch_d    = ch_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      wdog_d  = wdog_q;

      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (nat_valid_i) begin
               addr_d                      = nat_addr_i;
               addr_d[ADDR_W-1 -: SEL_W]   = ch_req;
               wdata_d                     = nat_wdata_i;
               wstrb_d                     = nat_wstrb_i;
               we_d                        = |nat_wstrb_i;
               ch_d                        = ch_req;
               if (ch_req_ok) begin
                  state_d = REQ;
               end else begin
                  // Nothing decodes here: answer at once with an error.
                  state_d = ACK;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end

         REQ: begin
            wdog_d = wdog_q + CNT_W'(1);
            if (wdog_hit) begin
               state_d = ACK;
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (ready_sel[ch_q]) begin
               if (we_q) begin
                  state_d = ACK;
                  err_d   = 1'b0;
               end else begin
                  state_d = RESP;
               end
            end
         end

         RESP: begin
            wdog_d = wdog_q + CNT_W'(1);
            if (wdog_hit) begin
               state_d = ACK;
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (rvalid_sel[ch_q]) begin
               state_d = ACK;
               err_d   = 1'b0;
               rdata_d = rdata_sel[ch_q];
            end
         end

         ACK: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered: derive them from the state being entered.
      ready_d  = (state_d == ACK);
      avalid_d = '0;
      if (state_d == REQ) begin
         for (int k = 0; k < N_CH; k++) begin
            avalid_d[k] = (ch_d == SEL_W'(k));
         end
      end
   end

   // NOTE: the latched address/data/strobes and read data are reset along
   // with the control state, so the shared IOb buses and nat_rdata_o come
   // out of reset at a known zero rather than at leftover contents.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         we_q     <= 1'b0;
         ch_q     <= '0;
         avalid_q <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         wdog_q   <= '0;
      end else if (cke_i) begin
         // NOTE: non-blocking assignments make every register sample the
         // pre-edge values, independent of statement order.
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         we_q     <= we_d;
         ch_q     <= ch_d;
         avalid_q <= avalid_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         wdog_q   <= wdog_d;
      end
   end

   assign nat_rdata_o  = rdata_q;
   assign nat_ready_o  = ready_q;
   assign nat_err_o    = err_q;
   assign iob_avalid_o = avalid_q;
   assign iob_addr_o   = addr_q;
   assign iob_wdata_o  = wdata_q;
   assign iob_wstrb_o  = wstrb_q;

endmodule

// File: tb/tb_iob_native_split.sv
// ---------------------------------------------------------------------------
// tb_iob_native_split
//
// Two bridge instances share clock, reset, clock enable and boot mode:
//   dut_a : N_CH=2, SEL_W=1, BOOT_CH=0, TIMEOUT_W=8 (table-driven traffic,
//           reset and clock-enable sequences)
//   dut_b : N_CH=3, SEL_W=2, BOOT_CH=0, TIMEOUT_W=4 (out-of-range and
//           watchdog sequences)
// Inputs change on the falling edge; outputs are sampled on the falling
// edge. Cycle n is the n-th falling edge after nat_valid_i was raised.
// ---------------------------------------------------------------------------
module tb_iob_native_split;

   logic clk_i = 1'b0;
   logic arst_i, cke_i, boot_i;

   always #5 clk_i = ~clk_i;

   // ---- dut_a signals ----
   logic        nat_valid_i, nat_instr_i;
   logic [31:0] nat_addr_i, nat_wdata_i;
   logic [3:0]  nat_wstrb_i;
   logic [31:0] nat_rdata_o;
   logic        nat_ready_o, nat_err_o;
   logic [1:0]  iob_avalid_o;
   logic [31:0] iob_addr_o, iob_wdata_o;
   logic [3:0]  iob_wstrb_o;
   logic [1:0]  iob_ready_i, iob_rvalid_i;
   logic [63:0] iob_rdata_i;

   // ---- dut_b signals ----
   logic        b_nat_valid_i, b_nat_instr_i;
   logic [31:0] b_nat_addr_i, b_nat_wdata_i;
   logic [3:0]  b_nat_wstrb_i;
   logic [31:0] b_nat_rdata_o;
   logic        b_nat_ready_o, b_nat_err_o;
   logic [2:0]  b_iob_avalid_o;
   logic [31:0] b_iob_addr_o, b_iob_wdata_o;
   logic [3:0]  b_iob_wstrb_o;
   logic [2:0]  b_iob_ready_i, b_iob_rvalid_i;
   logic [95:0] b_iob_rdata_i;

   iob_native_split #(
      .ADDR_W(32), .DATA_W(32), .N_CH(2), .SEL_W(1),
      .USE_BOOT(1'b1), .BOOT_CH(0), .TIMEOUT_W(8)
   ) dut_a (
      .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .boot_i(boot_i),
      .nat_valid_i(nat_valid_i), .nat_instr_i(nat_instr_i),
      .nat_addr_i(nat_addr_i), .nat_wdata_i(nat_wdata_i),
      .nat_wstrb_i(nat_wstrb_i), .nat_rdata_o(nat_rdata_o),
      .nat_ready_o(nat_ready_o), .nat_err_o(nat_err_o),
      .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
      .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
      .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
      .iob_rdata_i(iob_rdata_i)
   );

   iob_native_split #(
      .ADDR_W(32), .DATA_W(32), .N_CH(3), .SEL_W(2),
      .USE_BOOT(1'b1), .BOOT_CH(0), .TIMEOUT_W(4)
   ) dut_b (
      .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .boot_i(boot_i),
      .nat_valid_i(b_nat_valid_i), .nat_instr_i(b_nat_instr_i),
      .nat_addr_i(b_nat_addr_i), .nat_wdata_i(b_nat_wdata_i),
      .nat_wstrb_i(b_nat_wstrb_i), .nat_rdata_o(b_nat_rdata_o),
      .nat_ready_o(b_nat_ready_o), .nat_err_o(b_nat_err_o),
      .iob_avalid_o(b_iob_avalid_o), .iob_addr_o(b_iob_addr_o),
      .iob_wdata_o(b_iob_wdata_o), .iob_wstrb_o(b_iob_wstrb_o),
      .iob_ready_i(b_iob_ready_i), .iob_rvalid_i(b_iob_rvalid_i),
      .iob_rdata_i(b_iob_rdata_i)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // One directed transaction on dut_a with its hand-computed outcome.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
      logic        boot;
      logic        decoy;      // drive ready/rvalid on the other channel too
      int          rdy_dly;    // extra cycles before ready on the target
      int          rv_dly;     // extra cycles before rvalid on the target
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  exp_avalid;
      logic [31:0] exp_addr;
      logic [31:0] exp_rdata;
      int          exp_lat;    // cycle in which nat_ready_o is high
   } vec_t;

   function automatic vec_t mk(
      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
      input logic instr, input logic boot, input logic decoy,
      input int rdy_dly, input int rv_dly,
      input logic [31:0] rd0, input logic [31:0] rd1,
      input logic [1:0] exp_avalid, input logic [31:0] exp_addr,
      input logic [31:0] exp_rdata, input int exp_lat);
      vec_t v;
      v.addr = addr;   v.wdata = wdata;   v.wstrb = wstrb;
      v.instr = instr; v.boot = boot;     v.decoy = decoy;
      v.rdy_dly = rdy_dly; v.rv_dly = rv_dly;
      v.rd0 = rd0;     v.rd1 = rd1;
      v.exp_avalid = exp_avalid; v.exp_addr = exp_addr;
      v.exp_rdata = exp_rdata;   v.exp_lat = exp_lat;
      return v;
   endfunction

   task automatic run_vec(input int i, input vec_t v);
      int   c;
      logic rd;
      rd = (v.wstrb == 4'd0);
      boot_i      = v.boot;
      nat_instr_i = v.instr;
      nat_addr_i  = v.addr;
      nat_wdata_i = v.wdata;
      nat_wstrb_i = v.wstrb;
      iob_rdata_i = {v.rd1, v.rd0};
      nat_valid_i = 1'b1;
      c = 0;
      while (c < 40) begin
         @(negedge clk_i);
         c++;
         if (nat_ready_o) break;
         check($sformatf("v%0d_avalid_c%0d", i, c), 32'(iob_avalid_o),
               32'((c <= 1 + v.rdy_dly) ? v.exp_avalid : 2'b00));
         if (c == 1) begin
            check($sformatf("v%0d_addr", i), iob_addr_o, v.exp_addr);
            check($sformatf("v%0d_wstrb", i), 32'(iob_wstrb_o), 32'(v.wstrb));
            check($sformatf("v%0d_wdata", i), iob_wdata_o, v.wdata);
         end
         iob_ready_i  = (c == 1 + v.rdy_dly) ? v.exp_avalid : 2'b00;
         iob_rvalid_i = (rd && (c == 2 + v.rdy_dly + v.rv_dly)) ? v.exp_avalid : 2'b00;
         if (v.decoy) begin
            iob_ready_i  = iob_ready_i  | ~v.exp_avalid;
            iob_rvalid_i = iob_rvalid_i | ~v.exp_avalid;
         end
      end
      check($sformatf("v%0d_latency", i), c, v.exp_lat);
      check($sformatf("v%0d_err", i), 32'(nat_err_o), 32'd0);
      if (rd) check($sformatf("v%0d_rdata", i), nat_rdata_o, v.exp_rdata);
      check($sformatf("v%0d_avalid_ack", i), 32'(iob_avalid_o), 32'd0);
      nat_valid_i  = 1'b0;
      iob_ready_i  = '0;
      iob_rvalid_i = '0;
      @(negedge clk_i);
      check($sformatf("v%0d_pulse", i), 32'(nat_ready_o), 32'd0);
   endtask

   // Fixed-latency read on dut_b: ready in cycle 1, rvalid in cycle 2.
   task automatic b_read(input string tag, input logic [31:0] addr,
                         input logic [2:0] sel, input logic [31:0] data);
      for (int k = 0; k < 3; k++) begin
         b_iob_rdata_i[k*32 +: 32] = sel[k] ? data : (32'hBAD0_0000 | 32'(k));
      end
      b_nat_addr_i  = addr;
      b_nat_wstrb_i = 4'd0;
      b_nat_valid_i = 1'b1;
      @(negedge clk_i);
      check({tag, "_avalid"}, 32'(b_iob_avalid_o), 32'(sel));
      b_iob_ready_i = sel;
      @(negedge clk_i);
      check({tag, "_early_ready"}, 32'(b_nat_ready_o), 32'd0);
      b_iob_ready_i  = '0;
      b_iob_rvalid_i = sel;
      @(negedge clk_i);
      check({tag, "_ready"}, 32'(b_nat_ready_o), 32'd1);
      check({tag, "_rdata"}, b_nat_rdata_o, data);
      check({tag, "_err"}, 32'(b_nat_err_o), 32'd0);
      b_nat_valid_i  = 1'b0;
      b_iob_rvalid_i = '0;
      @(negedge clk_i);
      check({tag, "_pulse"}, 32'(b_nat_ready_o), 32'd0);
   endtask

   vec_t vecs[7];

   initial begin
      // Directed traffic for dut_a; latency = 2+rdy for writes,
      // 3+rdy+rv for reads.
      //             addr          wdata         wstrb  in  bt  dc  rdy rv  rd0           rd1           avalid  exp_addr      exp_rdata     lat
      vecs[0] = mk(32'h8000_0010, 32'h0000_0000, 4'h0, 0, 0, 0, 0, 0, 32'h1111_1111, 32'hDEAD_BEEF, 2'b10, 32'h8000_0010, 32'hDEAD_BEEF, 3);
      vecs[1] = mk(32'h0000_0100, 32'hCAFE_F00D, 4'h3, 0, 0, 0, 3, 0, 32'h0,         32'h0,         2'b01, 32'h0000_0100, 32'h0,         5);
      vecs[2] = mk(32'h8000_0000, 32'h0000_0000, 4'h0, 1, 1, 0, 0, 0, 32'h0BAD_C0DE, 32'h1234_5678, 2'b01, 32'h0000_0000, 32'h0BAD_C0DE, 3);
      vecs[3] = mk(32'h8000_0000, 32'h0000_0000, 4'h0, 1, 0, 0, 0, 0, 32'h0BAD_C0DE, 32'h1234_5678, 2'b10, 32'h8000_0000, 32'h1234_5678, 3);
      vecs[4] = mk(32'h8000_0004, 32'h0000_0000, 4'h0, 0, 1, 1, 1, 2, 32'h9999_9999, 32'hA5A5_5A5A, 2'b10, 32'h8000_0004, 32'hA5A5_5A5A, 6);
      vecs[5] = mk(32'hFFFF_FFFC, 32'h89AB_CDEF, 4'hF, 0, 0, 1, 0, 0, 32'h0,         32'h0,         2'b10, 32'hFFFF_FFFC, 32'h0,         2);
      vecs[6] = mk(32'h7FFF_FFF0, 32'h0102_0304, 4'h8, 0, 0, 0, 2, 0, 32'h0,         32'h0,         2'b01, 32'h7FFF_FFF0, 32'h0,         4);

      arst_i = 1'b1; cke_i = 1'b1; boot_i = 1'b0;
      nat_valid_i = 1'b0; nat_instr_i = 1'b0; nat_addr_i = '0;
      nat_wdata_i = '0; nat_wstrb_i = '0;
      iob_ready_i = '0; iob_rvalid_i = '0; iob_rdata_i = '0;
      b_nat_valid_i = 1'b0; b_nat_instr_i = 1'b0; b_nat_addr_i = '0;
      b_nat_wdata_i = '0; b_nat_wstrb_i = '0;
      b_iob_ready_i = '0; b_iob_rvalid_i = '0; b_iob_rdata_i = '0;

      // ---- reset state ----
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_avalid", 32'(iob_avalid_o), 32'd0);
      check("rst_ready", 32'(nat_ready_o), 32'd0);
      check("rst_err", 32'(nat_err_o), 32'd0);
      check("rst_rdata", nat_rdata_o, 32'd0);
      check("rst_addr", iob_addr_o, 32'd0);
      check("rst_wdata", iob_wdata_o, 32'd0);
      check("rst_wstrb", 32'(iob_wstrb_o), 32'd0);
      check("rst_b_avalid", 32'(b_iob_avalid_o), 32'd0);
      check("rst_b_ready", 32'(b_nat_ready_o), 32'd0);
      arst_i = 1'b0;
      @(negedge clk_i);

      // ---- table-driven traffic on dut_a ----
      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
      end
      boot_i = 1'b0;
      nat_instr_i = 1'b0;

      // ---- reset pulse while waiting in RESP ----
      nat_addr_i  = 32'h0000_0040;
      nat_wdata_i = 32'h1122_3344;
      nat_wstrb_i = 4'h0;
      iob_rdata_i = {32'h0, 32'h5555_5555};
      nat_valid_i = 1'b1;
      @(negedge clk_i);                       // cycle 1: REQ
      check("rresp_avalid", 32'(iob_avalid_o), 32'd1);
      iob_ready_i = 2'b01;
      @(negedge clk_i);                       // cycle 2: RESP
      iob_ready_i = 2'b00;
      #2 arst_i = 1'b1;
      #1;
      check("rresp_ready", 32'(nat_ready_o), 32'd0);
      check("rresp_rdata", nat_rdata_o, 32'd0);
      check("rresp_addr", iob_addr_o, 32'd0);
      check("rresp_wdata", iob_wdata_o, 32'd0);
      check("rresp_avalid0", 32'(iob_avalid_o), 32'd0);
      @(negedge clk_i);
      arst_i = 1'b0;                          // valid still high: restart
      @(negedge clk_i);                       // cycle 1 of the restart
      check("rreq_avalid", 32'(iob_avalid_o), 32'd1);
      #2 arst_i = 1'b1;
      #1;
      check("rreq_avalid_async", 32'(iob_avalid_o), 32'd0);
      nat_valid_i = 1'b0;
      @(negedge clk_i);
      arst_i = 1'b0;
      iob_rvalid_i = 2'b01;                   // stray response while IDLE
      @(negedge clk_i);
      iob_rvalid_i = 2'b00;
      check("rpost_ready", 32'(nat_ready_o), 32'd0);
      @(negedge clk_i);
      check("rpost_ready2", 32'(nat_ready_o), 32'd0);

      // ---- clock-enable stall while in REQ ----
      nat_addr_i  = 32'h8000_0200;
      nat_wdata_i = 32'h0F0F_0F0F;
      nat_wstrb_i = 4'hF;
      nat_valid_i = 1'b1;
      @(negedge clk_i);                       // cycle 1: REQ
      check("cke_avalid", 32'(iob_avalid_o), 32'd2);
      cke_i       = 1'b0;
      iob_ready_i = 2'b10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         check($sformatf("cke_hold_avalid_%0d", k), 32'(iob_avalid_o), 32'd2);
         check($sformatf("cke_hold_ready_%0d", k), 32'(nat_ready_o), 32'd0);
      end
      cke_i = 1'b1;
      @(negedge clk_i);
      check("cke_done_ready", 32'(nat_ready_o), 32'd1);
      check("cke_done_err", 32'(nat_err_o), 32'd0);
      check("cke_done_avalid", 32'(iob_avalid_o), 32'd0);
      nat_valid_i = 1'b0;
      iob_ready_i = 2'b00;
      @(negedge clk_i);
      check("cke_pulse", 32'(nat_ready_o), 32'd0);

      // ---- dut_b: good read, then out-of-range ----
      b_read("b_rd_ch2", 32'h8000_0020, 3'b100, 32'h55AA_1234);
      b_nat_addr_i  = 32'hC000_0000;
      b_nat_valid_i = 1'b1;
      @(negedge clk_i);                       // cycle 1: ACK with error
      check("oor_ready", 32'(b_nat_ready_o), 32'd1);
      check("oor_err", 32'(b_nat_err_o), 32'd1);
      check("oor_rdata", b_nat_rdata_o, 32'd0);
      check("oor_avalid", 32'(b_iob_avalid_o), 32'd0);
      b_nat_valid_i = 1'b0;
      @(negedge clk_i);
      check("oor_pulse", 32'(b_nat_ready_o), 32'd0);
      check("oor_avalid2", 32'(b_iob_avalid_o), 32'd0);

      // ---- dut_b: watchdog, ready never comes; ACK in cycle 17 ----
      b_nat_addr_i  = 32'h4000_0000;
      b_nat_valid_i = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk_i);
         check($sformatf("wd_avalid_c%0d", c), 32'(b_iob_avalid_o), 32'd2);
         check($sformatf("wd_ready_c%0d", c), 32'(b_nat_ready_o), 32'd0);
      end
      @(negedge clk_i);                       // cycle 17
      check("wd_ready", 32'(b_nat_ready_o), 32'd1);
      check("wd_err", 32'(b_nat_err_o), 32'd1);
      check("wd_rdata", b_nat_rdata_o, 32'd0);
      check("wd_avalid", 32'(b_iob_avalid_o), 32'd0);
      b_nat_valid_i  = 1'b0;
      b_iob_rdata_i  = {3{32'h7777_7777}};
      b_iob_rvalid_i = 3'b010;                // late response, must be ignored
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         check($sformatf("wd_stray_ready_%0d", k), 32'(b_nat_ready_o), 32'd0);
         check($sformatf("wd_stray_avalid_%0d", k), 32'(b_iob_avalid_o), 32'd0);
      end
      b_iob_rvalid_i = '0;
      b_read("b_rd_after_wd", 32'h4000_0008, 3'b010, 32'h1357_9BDF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
